// File: rtl/bridge_req_arbiter.sv
// bridge_req_arbiter: round-robin request arbiter with one-entry packet buffer and sleep handshake; BRIDGE_ARB_PRIO0_EN gives requester 0 strict priority.
module bridge_req_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int PACKET_WIDTH = 66
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_rd0_wr1,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wr_data,
  output logic [NUM_REQ-1:0]            o_ready,
  input  logic                          req_fifo_full,
  output logic                          req_fifo_wr_en,
  output logic [PACKET_WIDTH-1:0]       o_packet,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
  input  logic                          i_sleep_req,
  output logic                          o_sleep_ack,
  output logic                          o_busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {RUN, DRAIN, SLEEP} state_t;
  state_t state, state_n;
  logic buf_valid, accept, upd_last;
  logic [IW-1:0] last_grant, rr_winner, winner, idx;
  logic [NUM_REQ-1:0] req_rr;
  logic [DATA_WIDTH-1:0] sel_data;
  // Scan offsets farthest-first so the nearest requester after last_grant overwrites the rest.
  always_comb begin
    req_rr = i_req;
`ifdef BRIDGE_ARB_PRIO0_EN
    req_rr[0] = 1'b0;
`endif
    rr_winner = '0;
    idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(last_grant) + i) % NUM_REQ);
      rr_winner = req_rr[idx] ? idx : rr_winner;
    end
  end
`ifdef BRIDGE_ARB_PRIO0_EN
  assign winner   = i_req[0] ? '0 : rr_winner;
  assign upd_last = ~i_req[0];
`else
  assign winner   = rr_winner;
  assign upd_last = 1'b1;
`endif
  assign req_fifo_wr_en = buf_valid & ~req_fifo_full;
  assign o_busy         = buf_valid;
  assign accept   = ~i_rst & (state == RUN) & ~i_sleep_req & (|i_req) & (~buf_valid | req_fifo_wr_en);
  assign o_ready  = accept ? (NUM_REQ'(1) << winner) : '0;
  assign sel_data = i_rd0_wr1[winner] ? i_wr_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  always_comb begin
    state_n = state;
    case (state)
      RUN:     state_n = i_sleep_req ? DRAIN : RUN;
      DRAIN:   state_n = !i_sleep_req ? RUN : (!buf_valid ? SLEEP : DRAIN);
      SLEEP:   state_n = i_sleep_req ? SLEEP : RUN;
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= RUN;
      buf_valid   <= 1'b0;
      o_packet    <= '0;
      o_grant_id  <= '0;
      last_grant  <= IW'(NUM_REQ - 1);
      o_sleep_ack <= 1'b0;
    end else begin
      state       <= state_n;
      o_sleep_ack <= (state_n == SLEEP);
      if (accept) begin
        buf_valid  <= 1'b1;
        o_packet   <= {i_rd0_wr1[winner], 1'b1, i_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH], sel_data};
        o_grant_id <= winner;
        if (upd_last) last_grant <= winner;
      end else if (req_fifo_wr_en) begin
        buf_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bridge_req_arbiter.sv
// tb_bridge_req_arbiter: directed and random checks of bridge_req_arbiter against a cycle reference model.
module tb_bridge_req_arbiter;
  localparam int N = 4, AW = 32, DW = 32, PW = 66;
`ifdef BRIDGE_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  logic clk = 0, rst = 0, full = 0, sleep = 0;
  logic [N-1:0] req = '0, rw = '0, o_ready;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] data = '0;
  logic wr_en, o_sleep_ack, o_busy;
  logic [PW-1:0] o_packet;
  logic [1:0] o_grant_id;
  int checks = 0, failures = 0;
  int m_state, m_last, m_id, m_w;
  logic m_valid, exp_wr, exp_acc;
  logic [PW-1:0] m_pkt, obs_pkt;
  logic [N-1:0] exp_ready, obs_ready;
  logic obs_wr, obs_ack;
  logic [1:0] obs_id;

  bridge_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PACKET_WIDTH(PW)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_rd0_wr1(rw), .i_addr(addr), .i_wr_data(data),
    .o_ready(o_ready), .req_fifo_full(full), .req_fifo_wr_en(wr_en), .o_packet(o_packet),
    .o_grant_id(o_grant_id), .i_sleep_req(sleep), .o_sleep_ack(o_sleep_ack), .o_busy(o_busy));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick();
    if (PRIO && req[0]) return 0;
    for (int i = 1; i <= N; i++) begin
      int k = (m_last + i) % N;
      if (req[k] && !(PRIO && k == 0)) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_valid = 0; m_pkt = '0; m_id = 0; m_last = N - 1;
    exp_ready = '0;
  endtask

  task automatic step();
    logic old_valid;
    #1;
    m_w = pick();
    exp_wr = m_valid && !full;
    exp_acc = (m_state == 0) && !sleep && (m_w >= 0) && (!m_valid || exp_wr);
    exp_ready = exp_acc ? (N'(1) << m_w) : '0;
    obs_ready = o_ready; obs_wr = wr_en; obs_pkt = o_packet; obs_id = o_grant_id; obs_ack = o_sleep_ack;
    check("ready", 128'(o_ready), 128'(exp_ready));
    check("wr_en", 128'(wr_en), 128'(exp_wr));
    check("busy", 128'(o_busy), 128'(m_valid));
    check("sleep_ack", 128'(o_sleep_ack), 128'(m_state == 2));
    check("packet", 128'(o_packet), 128'(m_pkt));
    check("grant_id", 128'(o_grant_id), 128'(m_id));
    @(posedge clk);
    old_valid = m_valid;
    if (exp_acc) begin
      m_valid = 1;
      m_pkt = {rw[m_w], 1'b1, addr[m_w*AW +: AW], rw[m_w] ? data[m_w*DW +: DW] : 32'h0};
      m_id = m_w;
      if (!(PRIO && m_w == 0)) m_last = m_w;
    end else if (exp_wr) m_valid = 0;
    case (m_state)
      0: m_state = sleep ? 1 : 0;
      1: m_state = !sleep ? 0 : (!old_valid ? 2 : 1);
      default: m_state = sleep ? 2 : 0;
    endcase
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    req[k] = r; rw[k] = w; addr[k*AW +: AW] = a; data[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    req = '0; full = 0; sleep = 0;
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < N; k++)
      if (!req[k] || exp_ready[k])
        set_req(k, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom, $urandom);
    full = $urandom_range(0, 9) < 3;
    if ($urandom_range(0, 19) == 0) sleep = ~sleep;
  endtask

  initial begin
    do_reset();
    check("reset_busy", 128'(o_busy), 128'(0));
    check("reset_pkt", 128'(o_packet), 128'(0));
    // single write from requester 2
    set_req(2, 1, 1, 32'h1000, 32'hA5A5A5A5);
    step();
    check("t1_ready", 128'(obs_ready), 128'(4'b0100));
    req = '0;
    step();
    check("t1_wr", 128'(obs_wr), 128'(1));
    check("t1_pkt", 128'(obs_pkt), 128'({1'b1, 1'b1, 32'h1000, 32'hA5A5A5A5}));
    check("t1_id", 128'(obs_id), 128'(2));
    // all requesters active, fifo never full
    do_reset();
    for (int k = 0; k < N; k++) set_req(k, 1, k[0], 32'h100 * k, 32'h11 * k);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_order", 128'(obs_ready), 128'(N'(1) << (PRIO ? 0 : i % N)));
      if (i > 0) check("t2_wr", 128'(obs_wr), 128'(1));
    end
    // fifo full holds the buffer
    do_reset();
    set_req(0, 1, 1, 32'h2000, 32'h12345678);
    step();
    req = '0; set_req(1, 1, 0, 32'h3000, 32'h0);
    full = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_wr", 128'(obs_wr), 128'(0));
      check("t3_ready", 128'(obs_ready), 128'(0));
      check("t3_pkt", 128'(obs_pkt), 128'({1'b1, 1'b1, 32'h2000, 32'h12345678}));
    end
    full = 0;
    step();
    check("t3_release_wr", 128'(obs_wr), 128'(1));
    check("t3_b2b_ready", 128'(obs_ready), 128'(4'b0010));
    // sleep with a held packet
    do_reset();
    set_req(0, 1, 0, 32'h4000, 32'h0);
    step();
    req = '0; full = 1; sleep = 1;
    set_req(3, 1, 1, 32'h5000, 32'h55);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_no_acc", 128'(obs_ready), 128'(0));
      check("t4_ack_lo", 128'(obs_ack), 128'(0));
    end
    full = 0;
    step();
    check("t4_wr", 128'(obs_wr), 128'(1));
    step();
    check("t4_ack_wait", 128'(obs_ack), 128'(0));
    step();
    check("t4_ack", 128'(obs_ack), 128'(1));
    check("t4_sleep_ready", 128'(obs_ready), 128'(0));
    sleep = 0;
    step();
    check("t4_still_asleep", 128'(obs_ready), 128'(0));
    step();
    check("t4_resume", 128'(obs_ready), 128'(4'b1000));
    check("t4_ack_drop", 128'(obs_ack), 128'(0));
    // reset while the buffer is valid
    do_reset();
    set_req(1, 1, 1, 32'h6000, 32'h66);
    step();
    req = '0; full = 1;
    step();
    rst = 1;
    #1;
    check("t5_busy", 128'(o_busy), 128'(0));
    check("t5_wr", 128'(wr_en), 128'(0));
    check("t5_pkt", 128'(o_packet), 128'(0));
    check("t5_id", 128'(o_grant_id), 128'(0));
    check("t5_ack", 128'(o_sleep_ack), 128'(0));
    check("t5_ready", 128'(o_ready), 128'(0));
    model_reset();
    full = 0;
    for (int k = 0; k < N; k++) set_req(k, 1, 0, 32'h700 + k, 32'h0);
    @(negedge clk);
    rst = 0;
    step();
    check("t5_first", 128'(obs_ready), 128'(4'b0001));
`ifdef BRIDGE_ARB_PRIO0_EN
    do_reset();
    set_req(0, 1, 1, 32'h8000, 32'h80); set_req(1, 1, 1, 32'h8100, 32'h81); set_req(3, 1, 0, 32'h8300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_prio", 128'(obs_ready), 128'(4'b0001));
    end
    req[0] = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_alt", 128'(obs_ready), 128'(i[0] ? 4'b1000 : 4'b0010));
    end
`endif
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
